// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding, default
// sizing and the grant-id width helper used by the top and the picker.
package rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_MAX_HOLD = 8;

    // A single requester still needs a 1-bit id port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: rotates the request vector so the search
// starts just after last_id, then priority-encodes the rotated vector.
module rr_arbiter_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_id,
    output logic           any,
    output logic [IDW-1:0] win_id
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             start;

    assign any = |req;

    always_comb begin
        start  = (int'(last_id) + 1) % N;
        dbl    = {req, req};
        rot    = N'(dbl >> start);
        win_id = '0;
        // Descending scan so the lowest rotated position (highest priority) wins.
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                win_id = IDW'((start + j) % N);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant held until release, with
// a hold-time limit that revokes the grant while other requesters are waiting.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter  int N        = DEFAULT_N,
    parameter  int MAX_HOLD = DEFAULT_MAX_HOLD,
    localparam int IDW      = id_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           preempt
);

    localparam int              HCW      = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0]  HOLD_SAT = HCW'(MAX_HOLD);

    arb_state_t     state_reg;
    logic [IDW-1:0] last_id_reg;
    logic [HCW-1:0] hold_cnt_reg;

    logic           any;
    logic [IDW-1:0] win_id;
    logic           owner_req;
    logic           contended;

    rr_arbiter_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req     (req),
        .last_id (last_id_reg),
        .any     (any),
        .win_id  (win_id)
    );

    // gnt is one-hot on the owner, so masking with it isolates owner vs. others.
    assign owner_req = |(req & gnt);
    assign contended = |(req & ~gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            last_id_reg  <= IDW'(N - 1);
            hold_cnt_reg <= '0;
            gnt          <= '0;
            gnt_valid    <= 1'b0;
            gnt_id       <= '0;
            preempt      <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    hold_cnt_reg <= '0;
                    if (any) begin
                        gnt         <= N'(1) << win_id;
                        gnt_valid   <= 1'b1;
                        gnt_id      <= win_id;
                        last_id_reg <= win_id;
                        state_reg   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!owner_req) begin
                        // Release wins over a coincident timeout: no preempt pulse.
                        gnt          <= '0;
                        gnt_valid    <= 1'b0;
                        gnt_id       <= '0;
                        hold_cnt_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end else if (contended && (int'(hold_cnt_reg) >= MAX_HOLD - 1)) begin
                        // last_id_reg already holds the owner, so it drops to lowest priority.
                        gnt          <= '0;
                        gnt_valid    <= 1'b0;
                        gnt_id       <= '0;
                        hold_cnt_reg <= '0;
                        preempt      <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end else if (hold_cnt_reg != HOLD_SAT) begin
                        hold_cnt_reg <= hold_cnt_reg + HCW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
